// File: rtl/freq_gen_pkg.sv
// Shared defaults and state encoding for the programmable frequency generator.
package freq_gen_pkg;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned MAX_FREQ_DEF = 999_999;
  localparam int unsigned FREQ_W_DEF   = 20;
  localparam int unsigned HP_W_DEF     = 25;
  localparam int unsigned HALF_CLK     = CLK_FREQ_DEF / 2;

  typedef enum logic {
    IDLE,
    DIVIDE
  } gen_state_e;

endpackage

// File: rtl/programmable_frequency_generator_seq_divider.sv
// Restoring divider producing one quotient bit per clock; the quotient output
// only changes when a division completes.
module seq_divider
  import freq_gen_pkg::*;
#(
  parameter int unsigned FREQ_W = FREQ_W_DEF,
  parameter int unsigned HP_W   = HP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HP_W-1:0]   dividend,
  input  logic [FREQ_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [HP_W-1:0]   quotient
);

  localparam int unsigned CNT_W = $clog2(HP_W + 1);

  logic [CNT_W-1:0]  iter;
  logic [FREQ_W:0]   rem;
  logic [FREQ_W+1:0] trial;
  logic [FREQ_W+1:0] diff;
  logic [HP_W-1:0]   shreg;
  logic [FREQ_W-1:0] dvs;
  logic              q_bit;

  // The borrow out of the trial subtraction decides the quotient bit.
  always_comb begin
    trial = {rem, shreg[HP_W-1]};
    diff  = trial - {2'b00, dvs};
    q_bit = ~diff[FREQ_W+1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      iter     <= '0;
      rem      <= '0;
      shreg    <= '0;
      dvs      <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        rem   <= q_bit ? diff[FREQ_W:0] : trial[FREQ_W:0];
        shreg <= {shreg[HP_W-2:0], q_bit};
        iter  <= iter - CNT_W'(1);
        if (iter == CNT_W'(1)) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= {shreg[HP_W-2:0], q_bit};
        end
      end else if (start) begin
        busy  <= 1'b1;
        rem   <= '0;
        shreg <= dividend;
        dvs   <= divisor;
        iter  <= CNT_W'(HP_W);
      end
    end
  end

endmodule

// File: rtl/programmable_frequency_generator.sv
// 50 % duty square-wave source; load a frequency in Hz and the half-period is
// derived on-chip, with new periods applied only at toggle boundaries.
module programmable_frequency_generator
  import freq_gen_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned MAX_FREQ = MAX_FREQ_DEF,
  parameter int unsigned FREQ_W   = FREQ_W_DEF,
  parameter int unsigned HP_W     = HP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              load,
  input  logic              enable,
  output logic              signal_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [HP_W-1:0]   HALF       = HP_W'(CLK_FREQ / 2);
  localparam logic [FREQ_W-1:0] FREQ_LIMIT = FREQ_W'(MAX_FREQ);
  localparam logic [HP_W-1:0]   HP_ONE     = HP_W'(1);

  gen_state_e      state, state_next;
  logic            start, err_next, zero_next, zero_done, div_done;
  logic [HP_W-1:0] quotient;
  logic            pend_flag, pend_v;
  logic [HP_W-1:0] pend_hp, pend_hp_v;
  logic [HP_W-1:0] active_hp, cnt;

  seq_divider #(
    .FREQ_W (FREQ_W),
    .HP_W   (HP_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (HALF),
    .divisor  (freq_in),
    .busy     (busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_comb begin
    state_next = state;
    start      = 1'b0;
    err_next   = 1'b0;
    zero_next  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          if (freq_in > FREQ_LIMIT) begin
            err_next = 1'b1;
          end else if (freq_in == '0) begin
            zero_next = 1'b1;
          end else begin
            start      = 1'b1;
            state_next = DIVIDE;
          end
        end
      end
      DIVIDE:  if (div_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      err       <= 1'b0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_next;
      err       <= err_next;
      zero_done <= zero_next;
    end
  end

  assign done = div_done | zero_done;

  // A result arriving this cycle is visible to the counter immediately, so a
  // toggle boundary coinciding with done already picks up the new half-period.
  always_comb begin
    pend_v    = pend_flag | done;
    pend_hp_v = zero_done ? '0 : (div_done ? quotient : pend_hp);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_flag  <= 1'b0;
      pend_hp    <= '0;
      active_hp  <= '0;
      cnt        <= '0;
      signal_out <= 1'b0;
    end else begin
      if (done) begin
        pend_flag <= 1'b1;
        pend_hp   <= pend_hp_v;
      end
      if (active_hp == '0) begin
        cnt        <= '0;
        signal_out <= 1'b0;
        if (pend_v) begin
          active_hp <= pend_hp_v;
          pend_flag <= 1'b0;
        end
      end else if (!enable) begin
        cnt        <= '0;
        signal_out <= 1'b0;
      end else if (cnt == active_hp - HP_ONE) begin
        cnt <= '0;
        if (pend_v) begin
          active_hp  <= pend_hp_v;
          pend_flag  <= 1'b0;
          signal_out <= (pend_hp_v != '0) & ~signal_out;
        end else begin
          signal_out <= ~signal_out;
        end
      end else begin
        cnt <= cnt + HP_ONE;
      end
    end
  end

endmodule

// File: doc/programmable_frequency_generator.md
Name: programmable_frequency_generator

Overview:
Stimulus source for the frequency-meter chain. Generates a 50 %-duty square wave whose frequency in Hz is loaded as a binary integer. The half-period in clocks is computed on-chip by an iterative divider. Its output drives frequency_meter.signal_in on the board, or in loopback self-test, so it sits directly upstream of the measurement path.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
MAX_FREQ, 999_999, highest accepted frequency in Hz; matches the 6-digit meter range
FREQ_W, 20, width of freq_in
HP_W, 25, half-period counter and quotient width; equals $clog2(CLK_FREQ/2+1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
freq_in  in  FREQ_W  requested frequency in Hz; sampled only on a load
load  in  1  single-cycle request to apply freq_in
enable  in  1  1 = output runs; 0 = output forced low
signal_out  out  1  generated square wave
busy  out  1  divider is computing
done  out  1  one-cycle pulse when a new half-period is accepted
err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs and state:
  - signal_out=0, busy=0, done=0, err=0
  - FSM state = IDLE
  - active_hp=0, meaning stopped; pending_hp=0; counter=0
- Division: half-period hp = floor((CLK_FREQ/2) / freq_in).
  - Example: 1 kHz gives 25000; the output period is 2*hp clocks.
- FSM has two states, IDLE and DIVIDE.
- IDLE, load=1 with freq_in > MAX_FREQ: err=1 for one cycle; state, busy and output are unchanged.
- IDLE, load=1 with freq_in = 0: no division. done pulses the next cycle and pending_hp=0 (stop request).
- IDLE, load=1 with a valid nonzero freq_in: freq_in is latched and the divider starts. busy=1 from cycle N+1 through N+HP_W, i.e. 25 cycles.
  - In the cycle after the last iteration, busy=0 and done=1. pending_hp holds the quotient and a pending flag is set.
- DIVIDE: load is ignored (no err) and freq_in is not resampled.
- Running counter (when active_hp≠0 and enable=1):
  - cnt counts 0..active_hp-1.
  - At cnt = active_hp-1: signal_out toggles, cnt←0, and if the pending flag is set, active_hp←pending_hp and the flag clears.
  - Frequency changes therefore take effect only at a toggle boundary (glitch-free). The current half-period always completes at the old length.
- Stopped (active_hp=0) when a pending value arrives: it is applied immediately, with cnt=0 and signal_out=0. The first toggle comes hp clocks later.
- Stop request (pending_hp=0) while running: applied at the next toggle boundary.
  - If that toggle would drive signal_out high, it is forced to 0 instead.
  - signal_out then stays low.
- enable=0: signal_out=0 and cnt=0 in the same clock. active_hp and pending are kept, and the divider continues.
  - On enable 0→1: counting restarts from cnt=0 with the output low.
- load and a toggle boundary in the same cycle: independent. The toggle uses the old pending state, and the new load starts a division.
- rst asserted mid-division: busy drops asynchronously and the result is discarded.
- hp ≥ 25 for every legal freq_in, so the counter never sees hp=1 or hp=0 while running.

Decomposition:
- Package freq_gen_pkg holds:
  - CLK_FREQ, MAX_FREQ, FREQ_W and HP_W defaults
  - HALF_CLK = CLK_FREQ/2
  - the state enum {IDLE, DIVIDE}
- One sub-module, seq_divider: restoring divider, one quotient bit per cycle.
  - Ports: clk, rst, start, dividend[HP_W], divisor[FREQ_W], busy, done, quotient[HP_W].
  - Remainder width is FREQ_W+1.
- The top level contains the FSM, the pending register and the half-period counter/toggler.

Test Plan:
1. Reset, enable=1, load freq_in=1000 → busy high exactly 25 cycles, then done for 1 cycle. signal_out period is 50000 clocks (1 ms) with high = low = 25000 clocks. In loopback, frequency_meter reads 1000.
2. While running at 1000, load 10000 → the current half-period finishes at 25000 clocks, then the period becomes 5000 clocks, with no short or runt pulse.
3. Load 100000 → period 500 clocks. Then load 0 → the output ends low at the next boundary and stays low. done pulses for both loads.
4. Load 1_000_000 → err for 1 cycle, busy never rises, and signal_out keeps its previous period. Load 999_999 → hp = 25, period 50 clocks.
5. Second load during busy → ignored: no err, no second done, and the result matches the first freq_in.
6. rst=0 mid-division and mid-period → all outputs 0 immediately. After release, signal_out stays low until a new load.
